// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide,
// one iteration per cycle, with sign fix-up and a one-cycle done pulse.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Operand conditioning at acceptance: which operands are signed, and their magnitudes
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign a_neg    = a_signed & SrcA[WIDTH-1];
  assign b_neg    = b_signed & SrcB[WIDTH-1];
  assign a_abs    = a_neg ? (~SrcA + WIDTH'(1)) : SrcA;
  assign b_abs    = b_neg ? (~SrcB + WIDTH'(1)) : SrcB;

  // Multiply step: add multiplicand into the high half when the multiplier LSB is set, then shift
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_acc;
  assign mul_sum = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: quotient bits shift into acc low half as dividend bits shift out
  logic [WIDTH:0]   div_shift, div_trial;
  logic [DW-1:0]    div_acc;
  logic [WIDTH-1:0] div_rem;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_acc   = {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH]};

  // Sign correction and result selection
  logic [DW-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, fix_result;
  assign prod_s = neg_q ? (~acc_q + DW'(1)) : acc_q;
  assign quo_s  = div0_q ? '1 : (ovf_q ? a_raw_q :
                  (neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0]));
  assign rem_s  = div0_q ? a_raw_q : (ovf_q ? '0 :
                  (neg_q ? (~rem_q + WIDTH'(1)) : rem_q));

  always_comb begin
    fix_result = quo_s;
    if (!op_q[2]) begin
      fix_result = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[DW-1:WIDTH];
    end else if (op_q[1]) begin
      fix_result = rem_s;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_CALC;
          op_d    = Funct3;
          acc_d   = {{WIDTH{1'b0}}, Funct3[2] ? a_abs : b_abs};
          opnd_d  = Funct3[2] ? b_abs : a_abs;
          rem_d   = '0;
          a_raw_d = SrcA;
          neg_d   = (Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
          div0_d  = (SrcB == '0);
          ovf_d   = Funct3[2] && !Funct3[0] &&
                    (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_acc : mul_acc;
          if (op_q[2]) rem_d = div_rem;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_result;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // EX is held while an M op is requested, released in the done cycle
  assign stall  = start & ~done_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: latency-level reference model compared every cycle,
// directed RV32M vectors with literal results, and randomized ops with flushes.
module tb_mdu_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   Funct3 = '0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         stall, busy, done;
  logic [W-1:0] Result;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .Result(Result)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with 64-bit arithmetic
  function automatic logic [W-1:0] ref_result(input logic [2:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = '0;
    case (f)
      3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? '1 : ((a == 32'h8000_0000 && b == '1) ? a : 32'(sa / sb));
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: r = (b == 0) ? a : ((a == 32'h8000_0000 && b == '1) ? '0 : 32'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Timing model: an accepted op yields done at W+1 edges after acceptance
  logic         m_busy = 1'b0, m_done = 1'b0;
  logic [W-1:0] m_res = '0, m_pend = '0;
  int           m_age = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_age <= 0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      m_age  <= m_age + 1;
      if (flush) begin
        m_busy <= 1'b0;
      end else if (m_age == W) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
      end else if (m_age == W + 1) begin
        m_busy <= 1'b0;
      end
    end else if (start && !flush) begin
      m_busy <= 1'b1;
      m_age  <= 0;
      m_pend <= ref_result(Funct3, SrcA, SrcB);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", W'(busy), W'(m_busy));
      chk("done", W'(done), W'(m_done));
      chk("Result", Result, m_res);
      chk("stall", W'(stall), W'(start & ~m_done));
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    int lat;
    chk({name, " model"}, ref_result(f, a, b), exp);
    @(posedge clk); #1;
    start = 1'b1; Funct3 = f; SrcA = a; SrcB = b; flush = 1'b0;
    @(posedge clk); #1;
    SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    lat = 0;
    for (int i = 1; i <= W + 8; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk({name, " latency"}, W'(lat), W'(W + 1));
    chk({name, " Result"}, Result, exp);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic random_op();
    int  fa, age;
    bit  ended;
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'($urandom); SrcA = pick(); SrcB = pick();
    flush = ($urandom_range(0, 9) == 0);
    fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0;
    age = 0;
    ended = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (flush) begin flush = 1'b0; start = 1'b0; ended = 1'b1; break; end
      age++;
      SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
      if (done) begin
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        start = 1'b0; ended = 1'b1; break;
      end
      if (age == fa) flush = 1'b1;
    end
    if (!ended) chk("random op completion", W'(0), W'(1));
    start = 1'b0; flush = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    check_en = 1'b1;
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset Result", Result, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2);
    run_op("DIV -100/7", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    run_op("REM -100/7", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush during CALC iteration 10; Result keeps the REM ovf value
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1; flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("flush busy", W'(busy), W'(0));
    chk("flush done", W'(done), W'(0));
    chk("flush Result", Result, 32'd0);
    flush = 1'b0;
    run_op("MUL after flush", 3'd0, 32'd3, 32'd5, 32'd15);

    // Reset during CALC iteration 5 with start held through deassertion
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset busy", W'(busy), W'(0));
    chk("midreset done", W'(done), W'(0));
    chk("midreset Result", Result, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("restart busy", W'(busy), W'(1));
    begin
      int lat;
      lat = 0;
      for (int i = 1; i <= W + 8; i++) begin
        @(posedge clk); #1;
        if (done) begin lat = i; break; end
      end
      chk("restart latency", W'(lat), W'(W + 1));
      chk("restart Result", Result, 32'd14);
    end
    start = 1'b0;

    for (int n = 0; n < 80; n++) random_op();

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
